// File: rtl/queue_pkg.sv
// queue_pkg: helpers shared by the queue packer/unpacker pair.
//   lane_index : lane that the cnt-th item of a beat occupies.
//   keep_mask  : lane mask covering the first cnt items of a beat.
// Masks are returned at MAX_WORDS width; callers keep the low WORDS bits.
package queue_pkg;

   localparam int MAX_WORDS = 16;

   function automatic int lane_index(input int cnt, input int words, input bit msb_first);
      return msb_first ? (words - 1 - cnt) : cnt;
   endfunction

   function automatic logic [MAX_WORDS-1:0] keep_mask(input int cnt, input int words,
                                                     input bit msb_first);
      logic [MAX_WORDS-1:0] m;
      int l;
      m = '0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         if (i < cnt && i < words) begin
            l = lane_index(i, words, msb_first);
            m[l[3:0]] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/queue_packer.sv
// queue_packer: packs WORDS consecutive BITS-wide items into one wide beat.
//   clock, reset_n          : posedge clock, synchronous active-low reset
//   s_value/s_valid/s_ready : narrow item stream in
//   flush                   : close a partial beat early (held until taken)
//   m_value/m_keep/m_valid/m_ready : registered wide beat out, per-lane keep
module queue_packer
   import queue_pkg::*;
#(
   parameter int WORDS     = 4,
   parameter int BITS      = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [BITS-1:0]       s_value,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  flush,
   output logic [WORDS*BITS-1:0] m_value,
   output logic [WORDS-1:0]      m_keep,
   output logic                  m_valid,
   input  logic                  m_ready
);

   localparam int            CW   = $clog2(WORDS) + 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   logic [CW-1:0]          cnt, cnt_inc;
   logic [WORDS*BITS-1:0]  acc, merged;
   logic [MAX_WORDS-1:0]   keep_full;
   logic                   out_free, s_fire, complete, flush_go, load;
   int                     lane;

   always_comb begin
      out_free = !m_valid || m_ready;
      // Partial lanes can always absorb items; only the completing item
      // needs a free output register.
      s_ready  = reset_n && ((cnt < LAST) || out_free);
      s_fire   = s_valid && s_ready;
      complete = s_fire && (cnt == LAST);
      // Never emit an empty beat: flush needs stored data or a same-cycle item.
      flush_go = flush && out_free && ((cnt != '0) || s_fire);
      load     = complete || flush_go;
      cnt_inc  = cnt + CW'(s_fire);
      lane     = lane_index(int'(cnt), WORDS, MSB_FIRST != 0);
      merged   = acc;
      for (int i = 0; i < WORDS; i++) begin
         if (s_fire && i == lane) merged[i*BITS +: BITS] = s_value;
      end
      // Occupied lanes after this cycle's item; all ones on a completing accept.
      keep_full = keep_mask(int'(cnt_inc), WORDS, MSB_FIRST != 0);
   end

   // Accumulator and lane counter. Cleared on every beat load so unused
   // lanes of a flushed beat read as zero.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         cnt <= '0;
      end else if (s_fire) begin
         acc <= merged;
         cnt <= cnt_inc;
      end
   end

   // Output register: a new beat may replace the departing one in the same
   // cycle, so back-to-back beats have no bubble.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         m_value <= '0;
         m_keep  <= '0;
         m_valid <= 1'b0;
      end else if (load) begin
         m_value <= merged;
         m_keep  <= keep_full[WORDS-1:0];
         m_valid <= 1'b1;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_queue_packer.sv
// Scoreboard bench for queue_packer. Three instances:
//   dut0 WORDS=4 LSB-first, dut1 WORDS=4 MSB-first, dut2 WORDS=3 (random traffic).
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_queue_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  sv    [3];
   logic        svld  [3];
   logic        srdy  [3];
   logic        fl    [3];
   logic        mrdy  [3];
   logic        mvld  [3];
   logic [31:0] mval  [3];
   logic [3:0]  mkeep [3];
   logic [23:0] mval2;
   logic [2:0]  mkeep2;

   logic [35:0] q0[$], q1[$], q2[$];
   logic [7:0]  items[$];
   logic        held_v   [3];
   logic [31:0] held_val [3];
   logic [3:0]  held_keep[3];

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   queue_packer #(.WORDS(4), .BITS(8), .MSB_FIRST(0)) dut0 (
      .clock(clk), .reset_n(rst_n), .s_value(sv[0]), .s_valid(svld[0]), .s_ready(srdy[0]),
      .flush(fl[0]), .m_value(mval[0]), .m_keep(mkeep[0]), .m_valid(mvld[0]), .m_ready(mrdy[0]));

   queue_packer #(.WORDS(4), .BITS(8), .MSB_FIRST(1)) dut1 (
      .clock(clk), .reset_n(rst_n), .s_value(sv[1]), .s_valid(svld[1]), .s_ready(srdy[1]),
      .flush(fl[1]), .m_value(mval[1]), .m_keep(mkeep[1]), .m_valid(mvld[1]), .m_ready(mrdy[1]));

   queue_packer #(.WORDS(3), .BITS(8), .MSB_FIRST(0)) dut2 (
      .clock(clk), .reset_n(rst_n), .s_value(sv[2]), .s_valid(svld[2]), .s_ready(srdy[2]),
      .flush(fl[2]), .m_value(mval2), .m_keep(mkeep2), .m_valid(mvld[2]), .m_ready(mrdy[2]));

   assign mval[2]  = {8'h00, mval2};
   assign mkeep[2] = {1'b0, mkeep2};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic push_exp(input int i, input logic [31:0] v, input logic [3:0] k);
      case (i)
         0: q0.push_back({k, v});
         1: q1.push_back({k, v});
         default: q2.push_back({k, v});
      endcase
   endtask

   task automatic pop_chk(input int i);
      logic [35:0] e;
      int n;
      n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         total++;
         $display("FAIL beat_unexpected dut%0d: got %0h/%0h, expected no beat", i, mval[i], mkeep[i]);
      end else begin
         case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk($sformatf("beat_value dut%0d", i), 64'(mval[i]), 64'(e[31:0]));
         chk($sformatf("beat_keep dut%0d", i), 64'(mkeep[i]), 64'(e[35:32]));
      end
   endtask

   // Monitor: beat pops, stall stability, and dut2 acceptance model.
   initial begin
      for (int i = 0; i < 3; i++) held_v[i] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (rst_n && mvld[i]) begin
               if (held_v[i]) begin
                  chk($sformatf("stall_value dut%0d", i), 64'(mval[i]), 64'(held_val[i]));
                  chk($sformatf("stall_keep dut%0d", i), 64'(mkeep[i]), 64'(held_keep[i]));
               end
               if (mrdy[i]) begin
                  pop_chk(i);
                  held_v[i] = 1'b0;
               end else begin
                  held_v[i]    = 1'b1;
                  held_val[i]  = mval[i];
                  held_keep[i] = mkeep[i];
               end
            end else begin
               held_v[i] = 1'b0;
            end
         end
         if (rst_n && svld[2] && srdy[2]) begin
            items.push_back(sv[2]);
            if (items.size() == 3) begin
               push_exp(2, {8'h00, items[2], items[1], items[0]}, 4'b0111);
               items.delete();
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] v);
      int t;
      t = 0;
      sv[i] = v; svld[i] = 1'b1;
      @(negedge clk);
      while (!srdy[i] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!srdy[i]) begin
         total++;
         $display("FAIL send_timeout dut%0d: s_ready=0 after 50 cycles, expected 1", i);
      end
      @(posedge clk); #1;
      svld[i] = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sv[i] = '0; svld[i] = 1'b0; fl[i] = 1'b0; mrdy[i] = 1'b1;
      end
      step(2);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_mvalid dut%0d", i), 64'(mvld[i]), 64'd0);
         chk($sformatf("reset_sready dut%0d", i), 64'(srdy[i]), 64'd0);
      end
      chk("reset_mvalue", 64'(mval[0]), 64'd0);
      chk("reset_mkeep", 64'(mkeep[0]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);

      // Full beat, back-to-back items, m_valid for exactly one cycle.
      push_exp(0, 32'h44332211, 4'hF);
      send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
      @(negedge clk);
      chk("beat_valid_high", 64'(mvld[0]), 64'd1);
      @(negedge clk);
      chk("beat_valid_one_cycle", 64'(mvld[0]), 64'd0);
      step(1);

      // Stalled output: partial lanes still fill, completing item refused.
      mrdy[0] = 1'b0;
      push_exp(0, 32'h44332211, 4'hF);
      push_exp(0, 32'h88776655, 4'hF);
      send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
      send(0, 8'h55); send(0, 8'h66); send(0, 8'h77);
      sv[0] = 8'h88; svld[0] = 1'b1;
      @(negedge clk);
      chk("sready_full_stalled", 64'(srdy[0]), 64'd0);
      step(3);
      mrdy[0] = 1'b1;
      @(negedge clk);
      chk("sready_after_release", 64'(srdy[0]), 64'd1);
      @(posedge clk); #1;
      svld[0] = 1'b0;
      @(negedge clk);
      chk("second_beat_no_bubble", 64'(mvld[0]), 64'd1);
      step(2);

      // Flush of two stored items.
      push_exp(0, 32'h0000BBAA, 4'b0011);
      send(0, 8'hAA); send(0, 8'hBB);
      fl[0] = 1'b1;
      step(1);
      fl[0] = 1'b0;
      step(2);

      // Flush together with an item on an empty packer.
      push_exp(0, 32'h000000CC, 4'b0001);
      sv[0] = 8'hCC; svld[0] = 1'b1; fl[0] = 1'b1;
      step(1);
      svld[0] = 1'b0; fl[0] = 1'b0;
      step(2);

      // Flush with nothing stored: no beat.
      fl[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("empty_flush_no_beat", 64'(mvld[0]), 64'd0);
      end
      @(posedge clk); #1;
      fl[0] = 1'b0;
      step(1);

      // Reset mid-beat discards partial data.
      send(0, 8'hE1); send(0, 8'hE2);
      rst_n = 1'b0;
      step(1);
      @(negedge clk);
      chk("midreset_sready", 64'(srdy[0]), 64'd0);
      chk("midreset_mvalid", 64'(mvld[0]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp(0, 32'hD4D3D2D1, 4'hF);
      send(0, 8'hD1); send(0, 8'hD2); send(0, 8'hD3); send(0, 8'hD4);
      step(3);

      // MSB-first ordering and keep.
      push_exp(1, 32'h11223344, 4'hF);
      send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
      push_exp(1, 32'hAABB0000, 4'b1100);
      send(1, 8'hAA); send(1, 8'hBB);
      fl[1] = 1'b1;
      step(1);
      fl[1] = 1'b0;
      step(3);

      // Random valid/ready on the 3-lane instance.
      for (int c = 0; c < 400; c++) begin
         sv[2]   = 8'($urandom);
         svld[2] = ($urandom_range(0, 3) != 0);
         mrdy[2] = ($urandom_range(0, 2) != 0);
         step(1);
      end
      svld[2] = 1'b0; mrdy[2] = 1'b1;
      step(6);

      chk("drain_dut0", 64'(q0.size()), 64'd0);
      chk("drain_dut1", 64'(q1.size()), 64'd0);
      chk("drain_dut2", 64'(q2.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
